keypad_scan: RTL and testbench

//  4x4 matrix hex keypad scanner: input-side counterpart of the scanned 7-seg display path.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/kp_sync.sv | 25 ++
 rtl/keypad_scan.sv | 158 +++++++++++++++
 tb/tb_keypad_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and frame helpers for the 4x4 keypad scanner.
// Frame bit index is col*4 + row; a set bit means that key is pressed.
package keypad_pkg;

  localparam int NCOL = 4;
  localparam int NROW = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } kpState_t;

  // Indexed by col*4+row; physical rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [3:0] KEYMAP [NCOL*NROW] = '{
    4'h1, 4'h4, 4'h7, 4'hE,
    4'h2, 4'h5, 4'h8, 4'h0,
    4'h3, 4'h6, 4'h9, 4'hF,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic isOneHot(input logic [NCOL*NROW-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [3:0] onehotIdx(input logic [NCOL*NROW-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NCOL*NROW; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad row lines.
// Resets to all-ones so no key appears pressed while the chain refills.
module kp_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_async,
  output logic [3:0] o_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: column drive, row sampling, whole-frame debounce and
// a four-digit history buffer that feeds the 7-segment display directly.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  KCOL,
  input  logic [3:0]  KROW,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [15:0] hex_buf
);

  import keypad_pkg::*;

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_SCANS);

  logic [SLOT_W-1:0]        r_slot;
  logic [1:0]               r_col;
  logic [3:0]               r_kcol;
  logic [NCOL*NROW-1:0]     r_frame;
  logic                     r_strobe;

  kpState_t                 r_state;
  logic [7:0]               r_debCnt;
  logic [NCOL*NROW-1:0]     r_cand;
  logic                     r_keyValid;
  logic [3:0]               r_keyCode;
  logic                     r_keyDown;
  logic [15:0]              r_hexBuf;

  logic [3:0]               w_rowSync;
  logic                     w_slotLast;
  logic [1:0]               w_colNext;
  logic                     w_none;
  logic                     w_one;
  logic [7:0]               w_debNext;
  logic [3:0]               w_code;
  logic                     w_fire;
  logic                     w_relDone;

  kp_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (KROW),
    .o_sync  (w_rowSync)
  );

  assign w_slotLast = (r_slot == SLOT_LAST);
  assign w_colNext  = r_col + 2'd1;

  // Rows are sampled in the last cycle of each slot so the synchronizer has settled on the new column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= '0;
      r_col    <= 2'd0;
      r_kcol   <= 4'b1110;
      r_frame  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_slotLast && (r_col == 2'd3);
      if (w_slotLast) begin
        r_slot                    <= '0;
        r_col                     <= w_colNext;
        r_kcol                    <= ~(4'b0001 << w_colNext);
        r_frame[{r_col, 2'b00} +: 4] <= ~w_rowSync;
      end else begin
        r_slot <= r_slot + SLOT_W'(1);
      end
    end
  end

  assign w_none    = (r_frame == '0);
  assign w_one     = isOneHot(r_frame);
  assign w_debNext = (r_debCnt < DEB_MAX) ? r_debCnt + 8'd1 : r_debCnt;
  assign w_code    = KEYMAP[onehotIdx(r_frame)];

  // A ghosted (multi-key) frame never equals the one-hot candidate, so it breaks a press debounce
  assign w_fire = r_strobe && (
                    ((r_state == IDLE) && w_one && (DEB_MAX <= 8'd1)) ||
                    ((r_state == DEB_PRESS) && (r_frame == r_cand) && (w_debNext >= DEB_MAX)));
  assign w_relDone = r_strobe && w_none && (
                    ((r_state == PRESSED) && (DEB_MAX <= 8'd1)) ||
                    ((r_state == DEB_REL) && (w_debNext >= DEB_MAX)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_debCnt   <= 8'd0;
      r_cand     <= '0;
      r_keyValid <= 1'b0;
      r_keyCode  <= 4'h0;
      r_keyDown  <= 1'b0;
      r_hexBuf   <= 16'h0000;
    end else begin
      r_keyValid <= 1'b0;
      if (r_strobe) begin
        case (r_state)
          IDLE: begin
            if (w_one) begin
              r_cand   <= r_frame;
              r_debCnt <= 8'd1;
              r_state  <= w_fire ? PRESSED : DEB_PRESS;
            end
          end
          DEB_PRESS: begin
            if (r_frame == r_cand) begin
              r_debCnt <= w_debNext;
              if (w_fire) r_state <= PRESSED;
            end else begin
              r_debCnt <= 8'd0;
              r_state  <= IDLE;
            end
          end
          PRESSED: begin
            if (w_none) begin
              r_debCnt <= w_relDone ? 8'd0 : 8'd1;
              r_state  <= w_relDone ? IDLE : DEB_REL;
            end
          end
          DEB_REL: begin
            if (w_none) begin
              r_debCnt <= w_relDone ? 8'd0 : w_debNext;
              if (w_relDone) r_state <= IDLE;
            end else begin
              r_state <= PRESSED;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_debCnt <= 8'd0;
          end
        endcase
      end
      if (w_fire) begin
        r_keyValid <= 1'b1;
        r_keyCode  <= w_code;
        r_keyDown  <= 1'b1;
        r_hexBuf   <= {r_hexBuf[11:0], w_code};
      end
      if (w_relDone) begin
        r_keyDown <= 1'b0;
      end
    end
  end

  assign KCOL      = r_kcol;
  assign key_valid = r_keyValid;
  assign key_code  = r_keyCode;
  assign key_down  = r_keyDown;
  assign hex_buf   = r_hexBuf;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 16-clock frame and a passive keypad model
// that pulls a row low whenever a held key sits on the currently driven column.
module tb_keypad_scan;

  logic        clk;
  logic        rst_n;
  logic [3:0]  kcol;
  logic [3:0]  krow;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        keyDown;
  logic [15:0] hexBuf;

  logic [15:0] pressed;
  int          pulses;
  int          checkCount;
  int          passCount;

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .KCOL      (kcol),
    .KROW      (krow),
    .key_valid (keyValid),
    .key_code  (keyCode),
    .key_down  (keyDown),
    .hex_buf   (hexBuf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: key at bit col*4+row shorts its row to its column
  always_comb begin
    krow = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !kcol[c]) krow[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (keyValid === 1'b1) pulses++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int cycles);
    pressed = keys;
    waitClk(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_kcol"},  16'(kcol),     16'h000E);
    checkOutput({tag, "_valid"}, 16'(keyValid), 16'h0000);
    checkOutput({tag, "_code"},  16'(keyCode),  16'h0000);
    checkOutput({tag, "_down"},  16'(keyDown),  16'h0000);
    checkOutput({tag, "_hex"},   hexBuf,        16'h0000);
  endtask

  initial begin
    int          idxTab  [5] = '{0, 4, 8, 12, 5};
    logic [3:0]  codeTab [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
    logic [15:0] hexTab  [5] = '{16'h0061, 16'h0612, 16'h6123, 16'h123A, 16'h23A5};

    checkCount = 0;
    passCount  = 0;
    pulses     = 0;
    pressed    = 16'h0000;
    rst_n      = 1'b0;

    waitClk(3);
    checkReset("reset");
    rst_n = 1'b1;

    // Column walk: 1110 for slots 0..3, then one column per 4 clocks
    waitClk(3);  checkOutput("kcol_c0", 16'(kcol), 16'h000E);
    waitClk(1);  checkOutput("kcol_c1", 16'(kcol), 16'h000D);
    waitClk(4);  checkOutput("kcol_c2", 16'(kcol), 16'h000B);
    waitClk(4);  checkOutput("kcol_c3", 16'(kcol), 16'h0007);
    waitClk(4);  checkOutput("kcol_wrap", 16'(kcol), 16'h000E);
    waitClk(16);
    checkOutput("idle_pulses", 16'(pulses), 16'd0);
    checkOutput("idle_hex", hexBuf, 16'h0000);

    // '6' held from a frame boundary: event one clock after the second frame's strobe
    applyStimulus(16'h0200, 32);
    checkOutput("six_early_valid", 16'(keyValid), 16'h0000);
    checkOutput("six_early_down", 16'(keyDown), 16'h0000);
    waitClk(1);
    checkOutput("six_valid", 16'(keyValid), 16'h0001);
    checkOutput("six_code", 16'(keyCode), 16'h0006);
    checkOutput("six_down", 16'(keyDown), 16'h0001);
    checkOutput("six_hex", hexBuf, 16'h0006);
    waitClk(1);
    checkOutput("six_pulse_width", 16'(keyValid), 16'h0000);
    waitClk(46);
    applyStimulus(16'h0000, 32);
    checkOutput("six_rel_pending", 16'(keyDown), 16'h0001);
    waitClk(1);
    checkOutput("six_rel_done", 16'(keyDown), 16'h0000);
    checkOutput("six_pulses", 16'(pulses), 16'd1);
    waitClk(15);

    // Five clean presses shift through the history buffer
    for (int k = 0; k < 5; k++) begin
      applyStimulus(16'(1) << idxTab[k], 48);
      checkOutput("seq_code", 16'(keyCode), 16'(codeTab[k]));
      checkOutput("seq_hex", hexBuf, hexTab[k]);
      applyStimulus(16'h0000, 48);
    end
    checkOutput("seq_pulses", 16'(pulses), 16'd6);
    checkOutput("seq_down", 16'(keyDown), 16'h0000);

    // One-frame glitch, then a ghosting pair: neither may register
    applyStimulus(16'h0200, 16);
    applyStimulus(16'h0000, 48);
    checkOutput("glitch_pulses", 16'(pulses), 16'd6);
    applyStimulus(16'h0011, 64);
    checkOutput("multi_down", 16'(keyDown), 16'h0000);
    applyStimulus(16'h0000, 48);
    checkOutput("multi_pulses", 16'(pulses), 16'd6);
    checkOutput("multi_hex", hexBuf, 16'h23A5);

    // Roll-over: second key while first is held is ignored until a full release
    applyStimulus(16'h0200, 48);
    checkOutput("roll_six_code", 16'(keyCode), 16'h0006);
    applyStimulus(16'h0600, 48);
    checkOutput("roll_both_pulses", 16'(pulses), 16'd7);
    checkOutput("roll_both_down", 16'(keyDown), 16'h0001);
    applyStimulus(16'h0400, 48);
    checkOutput("roll_nine_pulses", 16'(pulses), 16'd7);
    checkOutput("roll_nine_code", 16'(keyCode), 16'h0006);
    checkOutput("roll_nine_down", 16'(keyDown), 16'h0001);
    applyStimulus(16'h0000, 48);
    checkOutput("roll_rel_down", 16'(keyDown), 16'h0000);
    applyStimulus(16'h0400, 48);
    checkOutput("roll_nine2_code", 16'(keyCode), 16'h0009);
    checkOutput("roll_nine2_hex", hexBuf, 16'hA569);
    checkOutput("roll_pulses", 16'(pulses), 16'd8);
    applyStimulus(16'h0000, 48);

    // Asynchronous reset during press debounce, key kept held
    applyStimulus(16'h0200, 20);
    rst_n = 1'b0;
    #1;
    checkReset("rst_debpress");
    waitClk(2);
    rst_n = 1'b1;
    waitClk(32);
    checkOutput("rst1_early", 16'(keyValid), 16'h0000);
    waitClk(1);
    checkOutput("rst1_valid", 16'(keyValid), 16'h0001);
    checkOutput("rst1_code", 16'(keyCode), 16'h0006);
    checkOutput("rst1_hex", hexBuf, 16'h0006);

    // Asynchronous reset while the key is registered and held
    waitClk(15);
    rst_n = 1'b0;
    #1;
    checkReset("rst_pressed");
    waitClk(2);
    rst_n = 1'b1;
    waitClk(33);
    checkOutput("rst2_valid", 16'(keyValid), 16'h0001);
    checkOutput("rst2_down", 16'(keyDown), 16'h0001);
    waitClk(15);
    applyStimulus(16'h0000, 48);
    checkOutput("rst2_rel_down", 16'(keyDown), 16'h0000);
    checkOutput("final_pulses", 16'(pulses), 16'd10);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
